// File: rtl/sdram_arbiter.sv
// Three-master arbiter in front of the SDRAM controller, with read-completion routing.
// Optional wait-based aging of pending masters: define SDRAM_ARB_AGING_EN.
module sdram_arbiter #(
    parameter int unsigned WAIT_LIMIT  = 64,
    parameter int unsigned CFIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  m_req,
    output logic [2:0]  m_ready,
    input  logic [77:0] m_address,
    input  logic [2:0]  m_write,
    input  logic [2:0]  m_burst,
    input  logic [11:0] m_wstrb,
    input  logic [95:0] m_wdata,
    output logic [2:0]  m_rvalid,
    output logic [31:0] m_rdata,
    output logic [8:0]  m_rtag,
    output logic [25:0] m_raddress,
    output logic [2:0]  m_complete,
    output logic [2:0]  sdram_request,
    input  logic        sdram_ready,
    output logic [25:0] sdram_address,
    output logic        sdram_write,
    output logic        sdram_burst,
    output logic [3:0]  sdram_wstrb,
    output logic [31:0] sdram_wdata,
    input  logic [31:0] sdram_rdata,
    input  logic [8:0]  sdram_rtag,
    input  logic [25:0] sdram_raddress,
    input  logic [2:0]  sdram_rvalid,
    input  logic        sdram_complete,
    output logic        arb_error
);

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned PW = (CFIFO_DEPTH > 1) ? $clog2(CFIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(CFIFO_DEPTH + 1);

    // Elaboration-time guard on parameter legality.
    if (WAIT_LIMIT < 1 || CFIFO_DEPTH < 2 || (CFIFO_DEPTH & (CFIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("sdram_arbiter: illegal WAIT_LIMIT or CFIFO_DEPTH");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [NM-1:0]   eligible;
    logic [NM-1:0]   winner;
    int unsigned     widx;

    logic [NM-1:0]   fifo_mem [CFIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Isolate the lowest set bit: lowest index wins.
    function automatic logic [NM-1:0] pick_first(input logic [NM-1:0] v);
        return v & (~v + NM'(1));
    endfunction

    assign accept     = (state == GRANT) && sdram_ready;
    assign m_ready    = accept ? sdram_request : '0;
    assign fifo_full  = (count == CW'(CFIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = accept && !sdram_write;
    assign pop        = sdram_complete && !fifo_empty;

    // Return path is a straight pass-through from the controller.
    assign m_rvalid   = sdram_rvalid;
    assign m_rdata    = sdram_rdata;
    assign m_rtag     = sdram_rtag;
    assign m_raddress = sdram_raddress;

    // Reads are masked while the completion FIFO cannot take another entry.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            eligible[i] = m_req[i] && (m_write[i] || !fifo_full);
        end
    end

`ifdef SDRAM_ARB_AGING_EN
    localparam int unsigned KW = $clog2(WAIT_LIMIT + 1);

    logic [NM-1:0][KW-1:0] age;
    logic [NM-1:0]         aged;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            age <= '0;
        end else begin
            for (int unsigned i = 0; i < NM; i++) begin
                if (m_ready[i]) begin
                    age[i] <= '0;
                end else if (m_req[i] && age[i] != KW'(WAIT_LIMIT)) begin
                    age[i] <= age[i] + KW'(1);
                end
            end
        end
    end

    always_comb begin
        aged = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            aged[i] = eligible[i] && (age[i] == KW'(WAIT_LIMIT));
        end
    end

    // Aged masters outrank everyone else; ties go to the lowest index.
    assign winner = (aged != '0) ? pick_first(aged) : pick_first(eligible);
`else
    assign winner = pick_first(eligible);
`endif

    always_comb begin
        widx = 0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (winner[i]) widx = i;
        end
    end

    // Grant FSM: fields are captured on entry to GRANT and held until accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sdram_request <= '0;
            sdram_address <= '0;
            sdram_write   <= 1'b0;
            sdram_burst   <= 1'b0;
            sdram_wstrb   <= '0;
            sdram_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner != '0) begin
                        state         <= GRANT;
                        sdram_request <= winner;
                        sdram_address <= m_address[AW*widx +: AW];
                        sdram_write   <= m_write[widx];
                        sdram_burst   <= m_burst[widx];
                        sdram_wstrb   <= m_wstrb[SW*widx +: SW];
                        sdram_wdata   <= m_wdata[DW*widx +: DW];
                    end
                end
                GRANT: begin
                    if (sdram_ready) begin
                        state         <= IDLE;
                        sdram_request <= '0;
                        sdram_address <= '0;
                        sdram_write   <= 1'b0;
                        sdram_burst   <= 1'b0;
                        sdram_wstrb   <= '0;
                        sdram_wdata   <= '0;
                    end
                end
            endcase
        end
    end

    // Completion FIFO storage holds the one-hot owner of each outstanding read.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= sdram_request;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            m_complete <= '0;
            arb_error  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            m_complete <= pop ? fifo_mem[rd_ptr] : '0;
            if (sdram_complete && fifo_empty) arb_error <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller between three bus masters: m0 = video/blitter, m1 = data cache, m2 = instruction cache.
- Selects one requester, holds its request fields stable until the controller accepts, then routes returned read data and burst-complete indications back to the right master.
- Sits between the masters and the SDRAM controller's arbiter interface.

Parameters:
- WAIT_LIMIT, 64, cycles a pending master may wait before it is promoted (aging feature only)
- CFIFO_DEPTH, 4, maximum outstanding reads tracked for completion routing (power of 2)

Ports:
- clock  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- m_req  in  3  per-master request; held high with stable fields until the matching m_ready pulse
- m_ready  out  3  one-hot acceptance pulse to the granted master
- m_address  in  78  3 x 26-bit byte address; master N at [26N+25:26N]
- m_write  in  3  1 = write
- m_burst  in  3  1 = 16-beat burst read
- m_wstrb  in  12  3 x 4 byte strobes
- m_wdata  in  96  3 x 32 write data; bits [8:0] carry the tag for reads
- m_rvalid  out  3  one-hot read-data-valid, equal to sdram_rvalid
- m_rdata  out  32  broadcast read data
- m_rtag  out  9  broadcast tag
- m_raddress  out  26  broadcast read address
- m_complete  out  3  one-hot end-of-read indication
- sdram_request  out  3  one-hot granted master to the controller; 0 when idle
- sdram_ready  in  1  controller accepted the request (ignored while sdram_request == 0)
- sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata  out  26/1/1/4/32  fields of the granted master
- sdram_rdata, sdram_rtag, sdram_raddress, sdram_rvalid, sdram_complete  in  32/9/26/3/1  controller return path
- arb_error  out  1  sticky: sdram_complete arrived with the completion FIFO empty

Behaviour:
- Reset is asynchronous, reset_n low:
  - state = IDLE
  - sdram_request, m_ready, m_complete, all sdram_* outputs = 0
  - completion FIFO empty, arb_error = 0
  - aging counters = 0
- Reset asserted mid-grant drops the request immediately. An in-flight controller transaction is not tracked.
- State machine:
  - IDLE: if any m_req is set, register the winner into the grant and the outputs, then go to GRANT. Otherwise stay.
  - GRANT: sdram_request = grant, and the fields mux from the grant register. They are held stable even if the controller sits in precharge, activate or refresh.
  - GRANT, sdram_ready = 1: m_ready[grant] pulses that same cycle and the next state is IDLE. There is a one-cycle bubble, so a master is never re-granted while its own m_req is still high.
- Winner selection: fixed priority m0 > m1 > m2.
- Reads and the completion FIFO:
  - A read (m_write = 0) is eligible only when the completion FIFO is not full. When full, the read is masked and the next eligible write or lower-priority master wins.
  - On read acceptance, push the grant (3-bit one-hot) into the completion FIFO.
  - On sdram_complete, pop the head and pulse m_complete = head for 1 cycle.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pop when empty: m_complete = 0, arb_error set until reset.
- Writes never enter the completion FIFO.
- Return path is combinational pass-through: m_rvalid = sdram_rvalid, m_rdata = sdram_rdata, m_rtag = sdram_rtag, m_raddress = sdram_raddress. Latency 0.

Optional Feature:
- Macro SDRAM_ARB_AGING_EN.
- When defined:
  - Each master has a counter that increments every cycle its m_req is high and it is not accepted.
  - The counter saturates at WAIT_LIMIT and clears on that master's m_ready.
  - Any master at WAIT_LIMIT outranks all non-aged masters. Among aged masters the lowest index wins.
- When undefined: no counters, pure fixed priority; m2 may starve.

Test Plan:
- Single write: m1 write to 0x0000100, wdata 0xDEADBEEF, wstrb 0xF; controller ready 2 cycles after grant -> sdram_request = 3'b010, fields stable for 3 cycles, m_ready = 3'b010 for exactly 1 cycle, then IDLE.
- Contention: m0, m1, m2 all raise req in the same cycle, each acked on first grant -> grant order m0, m1, m2 with one idle cycle between grants.
- Burst read, m2 at 0x0001000: controller returns 16 sdram_rvalid = 3'b100 then sdram_complete -> m_rvalid[2] asserted 16 times, m_complete = 3'b100 once, FIFO empty afterwards.
- FIFO full: 4 unfinished single reads from m1, then m1 read plus m2 write pending -> m2 write granted, m1 read held until the next sdram_complete.
- Spurious sdram_complete with FIFO empty -> m_complete = 0, arb_error = 1 and held until reset_n pulse.
- With SDRAM_ARB_AGING_EN, WAIT_LIMIT = 8: m0 requests continuously, m2 pending -> m2 granted once its counter reaches 8. Without the macro, m2 is never granted while m0 requests.
